// File: rtl/down_counter_timer.sv
// Loadable, enable-gated down-counter/timer with one-shot or auto-reload operation.
// A one-cycle terminal-count pulse is raised after exactly N enabled cycles.
module down_counter_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    // busy/done are registered alongside state so they always match it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            reload_reg <= '0;
            state      <= IDLE;
            tc         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count      <= load_val;
                reload_reg <= load_val;
                state      <= IDLE;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start && reload_reg != '0) begin
                            count <= reload_reg;
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (en) begin
                            if (count == ONE) begin
                                tc <= 1'b1;
                                if (auto_reload) begin
                                    count <= reload_reg;
                                end else begin
                                    count <= '0;
                                    state <= DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else if (count != '0) begin
                                count <= count - ONE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: table-driven vectors feeding an
// expectation queue, plus hand-written sequences for reset and long periods.
module tb_down_counter_timer;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         ld;
        logic [W-1:0] lv;
        logic         st;
        logic         en;
        logic         ar;
        logic [W-1:0] c;
        logic         tc;
        logic         b;
        logic         d;
    } vec_t;

    typedef struct {
        logic [W-1:0] c;
        logic         tc;
        logic         b;
        logic         d;
        string        nm;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    down_counter_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .en         (en),
        .auto_reload(auto_reload),
        .count      (count),
        .tc         (tc),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic ld, input int lv, input logic st, input logic e,
                               input logic ar, input int c, input logic t, input logic b,
                               input logic d);
        vec_t r;
        r.ld = ld; r.lv = W'(lv); r.st = st; r.en = e; r.ar = ar;
        r.c = W'(c); r.tc = t; r.b = b; r.d = d;
        return r;
    endfunction

    task automatic expect_out(input logic [W-1:0] c, input logic t, input logic b,
                              input logic d, input string nm);
        exp_t e;
        e.c = c; e.tc = t; e.b = b; e.d = d; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got count=%0d tc=%0b busy=%0b done=%0b, expected an entry",
                     count, tc, busy, done);
        end else begin
            e = exp_q.pop_front();
            if (count !== e.c || tc !== e.tc || busy !== e.b || done !== e.d) begin
                errors++;
                $display("FAIL %s: got count=%0d tc=%0b busy=%0b done=%0b, expected count=%0d tc=%0b busy=%0b done=%0b",
                         e.nm, count, tc, busy, done, e.c, e.tc, e.b, e.d);
            end
        end
    endtask

    // Drives one vector at the falling edge, checks #1 after the rising edge.
    task automatic apply(input vec_t x, input string nm);
        load = x.ld; load_val = x.lv; start = x.st; en = x.en; auto_reload = x.ar;
        expect_out(x.c, x.tc, x.b, x.d, nm);
        @(posedge clk);
        #1;
        check_out();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; en = 1'b0; auto_reload = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_out('0, 1'b0, 1'b0, 1'b0, "reset_state");
        check_out();
        rst = 1'b1;

        // One-shot of 5
        tbl.push_back(v(1, 5, 0, 0, 0, 5, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 5, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 4, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 3, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 2, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1));
        // Periodic of 3, then auto_reload dropped mid-run
        tbl.push_back(v(1, 3, 0, 0, 1, 3, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 3, 0, 1, 0));
        for (int p = 0; p < 3; p++) begin
            tbl.push_back(v(0, 0, 0, 1, 1, 2, 0, 1, 0));
            tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 1, 0));
            tbl.push_back(v(0, 0, 0, 1, 1, 3, 1, 1, 0));
        end
        tbl.push_back(v(0, 0, 0, 1, 0, 2, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 0, 1));
        // Enable gating 1,0,0,1,1,1
        tbl.push_back(v(1, 4, 0, 0, 0, 4, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 4, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 3, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 3, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 3, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 2, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 0, 1));
        // Start in RUN is ignored
        tbl.push_back(v(1, 6, 0, 0, 0, 6, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 0, 6, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 5, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 1, 0, 4, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 4, 0, 1, 0));
        // Abort at terminal cycle, then zero period disables start
        tbl.push_back(v(1, 2, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 2, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(v(1, 9, 1, 1, 1, 9, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 0, 0, 0));
        // Restart from DONE
        tbl.push_back(v(1, 2, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 2, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 2, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Period 1 periodic
        tbl.push_back(v(1, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 0, 1));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Maximum period 15: tc only on the fifteenth enabled edge
        apply(v(1, 15, 0, 0, 0, 15, 0, 0, 0), "max_load");
        apply(v(0, 0, 1, 0, 0, 15, 0, 1, 0), "max_start");
        for (int i = 0; i < 15; i++) begin
            apply(v(0, 0, 0, 1, 0, 14 - i, (i == 14), (i != 14), (i == 14)),
                  $sformatf("max_run%0d", i));
        end

        // Asynchronous reset mid-run with count 7
        apply(v(1, 9, 0, 0, 0, 9, 0, 0, 0), "rst_load");
        apply(v(0, 0, 1, 0, 0, 9, 0, 1, 0), "rst_start");
        apply(v(0, 0, 0, 1, 0, 8, 0, 1, 0), "rst_run8");
        apply(v(0, 0, 0, 1, 0, 7, 0, 1, 0), "rst_run7");
        #2 rst = 1'b0;
        #1;
        expect_out('0, 1'b0, 1'b0, 1'b0, "async_reset");
        check_out();
        @(negedge clk);
        rst = 1'b1;
        apply(v(0, 0, 1, 1, 0, 0, 0, 0, 0), "start_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
